fft_out_reorder: RTL and testbench

- Output stage directly downstream of Inplace_FFT.
- Captures each 64-point result frame, delivered as 32 consecutive cycles of two samples per cycle (pair p carries bins 2p and 2p+1), into a ping-pong buffer.
- Replays the frame one bin per cycle on a valid/ready stream with frame markers, in natural or fftshift order.
- Decouples the FFT's fixed-rate burst from a back-pressuring consumer.

---
 rtl/fft_out_reorder.sv | 197 +++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong frame buffer behind the in-place FFT.
// Captures 64-bin frames two bins per cycle and replays them one bin
// per cycle on a valid/ready stream, in natural or fftshift order.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   in_start            high with pair 0 of an incoming frame
//   inReal0/inImag0     bin 2p      inReal1/inImag1  bin 2p+1
//   out_valid/out_ready stream handshake
//   outReal/outImag     bin data    out_index        mapped bin number
//   out_first/out_last  frame markers
//   overflow            1-cycle pulse per dropped/aborted frame
//   drop_count          saturating count of overflow events
module fft_out_reorder #(
    parameter int N        = 64,
    parameter int W        = 16,
    parameter int FFTSHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_start,
    input  logic [W-1:0]         inReal0,
    input  logic [W-1:0]         inImag0,
    input  logic [W-1:0]         inReal1,
    input  logic [W-1:0]         inImag1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         outReal,
    output logic [W-1:0]         outImag,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    localparam int AW = $clog2(N);
    localparam int PW = AW - 1;
    localparam logic [AW-1:0] XMASK = (FFTSHIFT != 0) ? AW'(N / 2) : '0;
    localparam logic [PW-1:0] PLAST = PW'(N / 2 - 1);
    localparam logic [AW-1:0] RLAST = AW'(N - 1);

    typedef enum logic { W_IDLE, W_FILL } wstate_t;
    typedef enum logic { R_IDLE, R_SEND } rstate_t;

    // Both banks in one array, addressed {bank, bin}.
    logic [2*W-1:0] r_mem [0:2*N-1];

    wstate_t       r_wstate;
    rstate_t       r_rstate;
    logic          r_wbank;
    logic          r_rbank;
    logic [PW-1:0] r_pcnt;
    logic [AW-1:0] r_ridx;
    logic [1:0]    r_full;
    logic          r_ovf;
    logic [7:0]    r_drops;

    logic          w_accept;
    logic          w_done;
    logic [1:0]    w_clr;
    logic [1:0]    w_free;
    logic [1:0]    w_rf;
    logic          w_wsel;
    logic          w_rsel;
    logic          w_we;
    logic          w_wb;
    logic [PW-1:0] w_wp;
    logic [1:0]    w_mark;
    logic          w_drop;
    logic [AW-1:0] w_raddr;
    logic [2*W-1:0] w_word;

    assign w_accept = (r_rstate == R_SEND) && out_ready;
    assign w_done   = w_accept && (r_ridx == RLAST);
    assign w_clr    = w_done ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;
    // A bank released by the final read accept is writable on the same edge.
    assign w_free   = ~r_full | w_clr;
    assign w_wsel   = w_free[0] ? 1'b0 : 1'b1;
    // The reader may pick up a bank on the very edge it is marked full.
    assign w_rf     = r_full | w_mark;
    assign w_rsel   = r_full[0] ? 1'b0 : (r_full[1] ? 1'b1 : w_mark[1]);

    always_comb begin
        w_we   = 1'b0;
        w_wb   = r_wbank;
        w_wp   = r_pcnt;
        w_mark = 2'b00;
        w_drop = 1'b0;
        if (r_wstate == W_IDLE) begin
            if (in_start) begin
                if (|w_free) begin
                    w_we = 1'b1;
                    w_wb = w_wsel;
                    w_wp = '0;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end else begin
            w_we = 1'b1;
            if (in_start) begin
                w_wp   = '0;
                w_drop = 1'b1;
            end else if (r_pcnt == PLAST) begin
                w_mark[r_wbank] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{w_wb, w_wp, 1'b0}] <= {inReal0, inImag0};
            r_mem[{w_wb, w_wp, 1'b1}] <= {inReal1, inImag1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wbank  <= 1'b0;
            r_pcnt   <= '0;
            r_full   <= 2'b00;
            r_ovf    <= 1'b0;
            r_drops  <= '0;
        end else begin
            r_full <= (r_full | w_mark) & ~w_clr;
            r_ovf  <= w_drop;
            if (w_drop && (r_drops != 8'hFF)) begin
                r_drops <= r_drops + 8'd1;
            end
            unique case (r_wstate)
                W_IDLE: begin
                    if (in_start && (|w_free)) begin
                        r_wbank  <= w_wsel;
                        r_pcnt   <= PW'(1);
                        r_wstate <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (in_start) begin
                        r_pcnt <= PW'(1);
                    end else if (r_pcnt == PLAST) begin
                        r_wstate <= W_IDLE;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rbank  <= 1'b0;
            r_ridx   <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (|w_rf) begin
                        r_rbank  <= w_rsel;
                        r_ridx   <= '0;
                        r_rstate <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (w_accept) begin
                        r_ridx <= r_ridx + 1'b1;
                        if (w_done) begin
                            // Other bank ready: chain straight into it.
                            if (w_rf[~r_rbank]) begin
                                r_rbank <= ~r_rbank;
                            end else begin
                                r_rstate <= R_IDLE;
                            end
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign w_raddr    = r_ridx ^ XMASK;
    assign w_word     = r_mem[{r_rbank, w_raddr}];
    assign out_valid  = (r_rstate == R_SEND);
    assign outReal    = out_valid ? w_word[2*W-1:W] : '0;
    assign outImag    = out_valid ? w_word[W-1:0] : '0;
    assign out_index  = out_valid ? w_raddr : '0;
    assign out_first  = out_valid && (r_ridx == '0);
    assign out_last   = out_valid && (r_ridx == RLAST);
    assign overflow   = r_ovf;
    assign drop_count = r_drops;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: natural and fftshift instances share stimulus;
// a queue scoreboard checks every accepted beat of the monitored instance.
module tb_fft_out_reorder;

    localparam int N = 64;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic [W-1:0] inReal0, inImag0, inReal1, inImag1;
    logic         out_ready;

    logic         v0, f0, l0, o0, v1, f1, l1, o1;
    logic [W-1:0] re0, im0, re1, im1;
    logic [5:0]   x0, x1;
    logic [7:0]   dc0, dc1;

    always #5 clk = ~clk;

    fft_out_reorder #(.N(N), .W(W), .FFTSHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_start(in_start),
        .inReal0(inReal0), .inImag0(inImag0),
        .inReal1(inReal1), .inImag1(inImag1),
        .out_valid(v0), .out_ready(out_ready),
        .outReal(re0), .outImag(im0), .out_index(x0),
        .out_first(f0), .out_last(l0),
        .overflow(o0), .drop_count(dc0)
    );

    fft_out_reorder #(.N(N), .W(W), .FFTSHIFT(1)) dut1 (
        .clk(clk), .rst(rst), .in_start(in_start),
        .inReal0(inReal0), .inImag0(inImag0),
        .inReal1(inReal1), .inImag1(inImag1),
        .out_valid(v1), .out_ready(out_ready),
        .outReal(re1), .outImag(im1), .out_index(x1),
        .out_first(f1), .out_last(l1),
        .overflow(o1), .drop_count(dc1)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit sel  = 0;
    int rmode = 0;

    logic [39:0] sb[$];

    int first_valid, ovf_cyc, ovf_cnt, acc_cnt, last_acc;

    logic        mv;
    logic [39:0] mword;
    assign mv    = sel ? v1 : v0;
    assign mword = sel ? {re1, im1, x1, f1, l1} : {re0, im0, x0, f0, l0};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    bit          stall_pend = 0;
    logic [39:0] stall_word;
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 0;
        end else begin
            if (mv && first_valid < 0) first_valid = cyc;
            if (o0) begin
                ovf_cnt++;
                ovf_cyc = cyc;
            end
            if (stall_pend && mv) chk("stall_hold", mword, stall_word);
            stall_pend = mv && !out_ready;
            stall_word = mword;
            if (mv && out_ready) begin
                acc_cnt++;
                last_acc = cyc;
                if (sb.size() == 0) begin
                    chk("extra_beat", mword, 40'h0);
                end else begin
                    chk($sformatf("beat%0d", acc_cnt - 1), mword,
                        sb.pop_front());
                end
            end
        end
    end

    task automatic set_ready();
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = (cyc >= 100);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        set_ready();
    endtask

    task automatic clear_stats();
        cyc = 0;
        first_valid = -1;
        ovf_cyc = -1;
        ovf_cnt = 0;
        acc_cnt = 0;
        last_acc = -1;
        set_ready();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_frame(input int base, input int npairs,
                              input bit push);
        int a;
        if (push) begin
            for (int j = 0; j < N; j++) begin
                a = sel ? (j ^ (N / 2)) : j;
                sb.push_back({16'(base + a), 16'(-(base + a)), 6'(a),
                              1'(j == 0), 1'(j == N - 1)});
            end
        end
        for (int p = 0; p < npairs; p++) begin
            in_start = (p == 0);
            inReal0  = 16'(base + 2 * p);
            inImag0  = 16'(-(base + 2 * p));
            inReal1  = 16'(base + 2 * p + 1);
            inImag1  = 16'(-(base + 2 * p + 1));
            tick();
        end
        in_start = 1'b0;
        inReal0 = '0; inImag0 = '0; inReal1 = '0; inImag1 = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || mv) && n < budget) begin
            tick();
            n++;
        end
        chk("drained", 64'(sb.size()), 64'd0);
        chk("idle_after", 64'(mv), 64'd0);
    endtask

    typedef struct {
        bit shift;
        int rm;
        int base;
        int lat;
        int beats;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{0, 0, 0,     32, 64};
        vt[1] = '{1, 0, 0,     32, 64};
        vt[2] = '{0, 1, 1000,  32, 64};
        vt[3] = '{1, 1, -500,  32, 64};
        vt[4] = '{0, 0, 32700, 32, 64};

        rst = 1'b1;
        in_start = 1'b0;
        out_ready = 1'b0;
        inReal0 = '0; inImag0 = '0; inReal1 = '0; inImag1 = '0;
        #2;
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_real",  64'(re0), 64'd0);
        chk("rst_imag",  64'(im0), 64'd0);
        chk("rst_index", 64'(x0), 64'd0);
        chk("rst_first", 64'(f0), 64'd0);
        chk("rst_last",  64'(l0), 64'd0);
        chk("rst_ovf",   64'(o0), 64'd0);
        chk("rst_drops", 64'(dc0), 64'd0);
        clear_stats();
        do_reset();

        for (int i = 0; i < 5; i++) begin
            sel = vt[i].shift;
            rmode = vt[i].rm;
            clear_stats();
            send_frame(vt[i].base, N / 2, 1'b1);
            wait_drain(400);
            chk($sformatf("v%0d_latency", i), 64'(first_valid),
                64'(vt[i].lat));
            chk($sformatf("v%0d_beats", i), 64'(acc_cnt),
                64'(vt[i].beats));
            chk($sformatf("v%0d_drops", i), 64'(dc0), 64'd0);
        end

        // Ping-pong: A and B buffered, C dropped, then A,B back-to-back.
        sel = 0;
        rmode = 2;
        do_reset();
        clear_stats();
        send_frame(100, N / 2, 1'b1);
        send_frame(2000, N / 2, 1'b1);
        send_frame(5000, N / 2, 1'b0);
        wait_drain(400);
        chk("pp_latency", 64'(first_valid), 64'd32);
        chk("pp_ovf_cyc", 64'(ovf_cyc), 64'd65);
        chk("pp_ovf_cnt", 64'(ovf_cnt), 64'd1);
        chk("pp_drops0", 64'(dc0), 64'd1);
        chk("pp_drops1", 64'(dc1), 64'd1);
        chk("pp_beats", 64'(acc_cnt), 64'd128);
        chk("pp_last_acc", 64'(last_acc), 64'd227);

        // Abort: restart at cycle 10 into the same bank.
        rmode = 0;
        do_reset();
        clear_stats();
        send_frame(300, 10, 1'b0);
        send_frame(700, N / 2, 1'b1);
        wait_drain(400);
        chk("ab_ovf_cyc", 64'(ovf_cyc), 64'd11);
        chk("ab_ovf_cnt", 64'(ovf_cnt), 64'd1);
        chk("ab_drops", 64'(dc0), 64'd1);
        chk("ab_latency", 64'(first_valid), 64'd42);

        // Reset during beat 20, then a fresh frame.
        do_reset();
        clear_stats();
        send_frame(900, N / 2, 1'b1);
        begin
            int n = 0;
            while (acc_cnt < 20 && n < 200) begin
                tick();
                n++;
            end
        end
        chk("mid_beat20", 64'(acc_cnt), 64'd20);
        rst = 1'b1;
        #1;
        chk("mid_valid", 64'(v0), 64'd0);
        chk("mid_real", 64'(re0), 64'd0);
        chk("mid_first", 64'(f0), 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        clear_stats();
        send_frame(50, N / 2, 1'b1);
        wait_drain(400);
        chk("mid_latency", 64'(first_valid), 64'd32);
        chk("mid_beats", 64'(acc_cnt), 64'd64);
        chk("mid_drops", 64'(dc0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
